// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state encodings and default width for the digit-serial subtractor
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_stage.sv
// serial_subtractor_stage: full adder and the two-bit ripple stage built from two of them
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module two_bit_sub_stage (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] d,
    output logic       cout
);
    logic c_mid;

    full_adder u_fa0 (.a(a[0]), .b(b[0]), .ci(cin),   .s(d[0]), .co(c_mid));
    full_adder u_fa1 (.a(a[1]), .b(b[1]), .ci(c_mid), .s(d[1]), .co(cout));
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes x - y two bits per clock as x + ~y + 1 through an iterated two-bit stage
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("serial_subtractor: WIDTH must be even and >= 2");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic             carry_q, carry_d, xs_q, xs_d, ys_q, ys_d;
    logic             borrow_q, borrow_d, ovf_q, ovf_d;
    logic [1:0]       d;
    logic             cout;

    two_bit_sub_stage u_stage (
        .a   (a_q[1:0]),
        .b   (b_q[1:0]),
        .cin (carry_q),
        .d   (d),
        .cout(cout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        xs_d     = xs_q;
        ys_d     = ys_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        case (state_q)
            RUN: begin
                diff_d  = WIDTH'({d, diff_q} >> 2);
                a_d     = a_q >> 2;
                b_d     = b_q >> 2;
                carry_d = cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    borrow_d = ~cout;
                    // d[1] becomes the result sign bit on this edge
                    ovf_d    = (xs_q != ys_q) && (d[1] != xs_q);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Accept from IDLE or DONE; diff is left to be overwritten by the shift
        if (start && state_q != RUN) begin
            state_d  = RUN;
            a_d      = x;
            b_d      = ~y;
            carry_d  = 1'b1;
            cnt_d    = '0;
            xs_d     = x[WIDTH-1];
            ys_d     = y[WIDTH-1];
            borrow_d = 1'b0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            xs_q     <= 1'b0;
            ys_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            xs_q     <= xs_d;
            ys_q     <= ys_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = state_q == RUN;
    assign done     = state_q == DONE;
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of the serial subtractor with hand-computed results
module tb_serial_subtractor;

    logic       clk, rst, start;
    logic [7:0] x, y, diff;
    logic       busy, done, borrow, overflow;
    int         errors = 0;
    int         checks = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // start an operation now and wait for its done cycle; returns inside the DONE cycle
    task automatic do_op(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                         input logic [7:0] ed, input logic eb, input logic eo);
        int bc;
        bc = 0;
        start = 1'b1;
        x = xv;
        y = yv;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (busy) bc++;
            tick();
        end
        check({tag, " done"}, done, 1);
        check({tag, " busy_cycles"}, bc, 4);
        check({tag, " busy_in_done"}, busy, 0);
        check({tag, " diff"}, diff, ed);
        check({tag, " borrow"}, borrow, eb);
        check({tag, " overflow"}, overflow, eo);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        x = '0;
        y = '0;
        #2;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset diff", diff, 0);
        check("reset flags", {borrow, overflow}, 0);
        #10 rst = 1'b0;
        tick();

        do_op("basic", 8'd100, 8'd37, 8'h3F, 0, 0);
        tick();
        check("basic pulse_once", done, 0);
        do_op("under1", 8'd37, 8'd100, 8'hC1, 1, 0);
        do_op("under2", 8'h00, 8'h01, 8'hFF, 1, 0);
        do_op("ovf1", 8'h80, 8'h01, 8'h7F, 0, 1);
        do_op("ovf2", 8'h7F, 8'hFF, 8'h80, 1, 1);
        do_op("y_zero", 8'h5A, 8'h00, 8'h5A, 0, 0);
        tick();

        // start held high through RUN while operands wander
        start = 1'b1;
        x = 8'd10;
        y = 8'd3;
        tick();
        for (int i = 0; i < 20 && !done; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            tick();
        end
        check("held done", done, 1);
        check("held diff", diff, 8'd7);
        check("held flags", {borrow, overflow}, 0);
        do_op("b2b_equal", 8'd5, 8'd5, 8'h00, 0, 0);

        // abort between the second and third digit edges
        start = 1'b1;
        x = 8'd100;
        y = 8'd37;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("mid busy", busy, 1);
        check("mid diff_partial", diff, 8'hF0);
        #2 rst = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort diff", diff, 0);
        check("abort flags", {borrow, overflow}, 0);
        tick();
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort no_done", {done, busy}, 0);
        end
        do_op("after_rst", 8'd255, 8'd1, 8'hFE, 0, 0);

        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle ctrl", {done, busy}, 0);
            check("idle hold", {diff, borrow, overflow}, {8'hFE, 1'b0, 1'b0});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
